// File: rtl/spi_serf.sv
// rtl/spi_serf.sv - SPI serf endpoint, WIDTH-bit MSB-first frames; optional MISO_TRISTATE_EN releases MISO while SS_n is high
module spi_serf #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             SS_n,
   input  logic             SCLK,
   input  logic             MOSI,
   input  logic [WIDTH-1:0] tx_data,
   output logic             MISO,
   output logic [WIDTH-1:0] cmd,
   output logic             rdy,
   output logic             frm_err,
   output logic             busy
);

   // Counter must reach WIDTH+1 so an over-long frame is distinguishable from a good one
   localparam int               CNT_W    = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WIDTH + 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t state;
   state_t state_nxt;

   logic ss_ff1, ss_ff2, ss_ff3;
   logic sclk_ff1, sclk_ff2, sclk_ff3;
   logic mosi_ff1, mosi_ff2, mosi_ff3;

   logic ss_fall;
   logic ss_rise;
   logic sclk_rise;

   logic [WIDTH-1:0] shift_reg;
   logic [CNT_W-1:0] bit_cnt;

   // Post-reset qualification: the SS_n chain resets high, so a select that is
   // already low when reset releases would look like a fresh falling edge.
   logic [1:0] settle_cnt;
   logic       armed;

   logic start;
   logic shift_en;
   logic end_good;
   logic end_bad;

   // Three-flop synchronizers; select and clock idle high, data idles low
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ss_ff1   <= 1'b1;
         ss_ff2   <= 1'b1;
         ss_ff3   <= 1'b1;
         sclk_ff1 <= 1'b1;
         sclk_ff2 <= 1'b1;
         sclk_ff3 <= 1'b1;
         mosi_ff1 <= 1'b0;
         mosi_ff2 <= 1'b0;
         mosi_ff3 <= 1'b0;
      end else begin
         ss_ff1   <= SS_n;
         ss_ff2   <= ss_ff1;
         ss_ff3   <= ss_ff2;
         sclk_ff1 <= SCLK;
         sclk_ff2 <= sclk_ff1;
         sclk_ff3 <= sclk_ff2;
         mosi_ff1 <= MOSI;
         mosi_ff2 <= mosi_ff1;
         mosi_ff3 <= mosi_ff2;
      end
   end

   // mosi_ff3 lines up with sclk_ff3, so at sclk_rise it still holds the pre-rise bit
   assign sclk_rise = sclk_ff2 & ~sclk_ff3;
   assign ss_fall   = ~ss_ff2 & ss_ff3;
   assign ss_rise   = ss_ff2 & ~ss_ff3;

   // Arm frame acceptance only once the synchronized select has been seen high
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         settle_cnt <= 2'd0;
         armed      <= 1'b0;
      end else begin
         if (settle_cnt != 2'd3) begin
            settle_cnt <= settle_cnt + 2'd1;
         end
         if ((settle_cnt == 2'd3) && ss_ff3) begin
            armed <= 1'b1;
         end
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and datapath strobes; end of frame takes priority over a coincident clock edge
   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      shift_en  = 1'b0;
      end_good  = 1'b0;
      end_bad   = 1'b0;
      case (state)
         IDLE: begin
            if (ss_fall && armed) begin
               start     = 1'b1;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (ss_rise) begin
               state_nxt = IDLE;
               if (bit_cnt == CNT_FULL) begin
                  end_good = 1'b1;
               end else begin
                  end_bad = 1'b1;
               end
            end else if (sclk_rise) begin
               shift_en = 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Shift register: response loaded at frame start, command shifted in behind it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_reg <= '0;
      end else if (start) begin
         shift_reg <= tx_data;
      end else if (shift_en) begin
         shift_reg <= {shift_reg[WIDTH-2:0], mosi_ff3};
      end
   end

   // Bit counter, saturating one past a full frame
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt <= '0;
      end else if (start) begin
         bit_cnt <= '0;
      end else if (shift_en && (bit_cnt != CNT_SAT)) begin
         bit_cnt <= bit_cnt + 1'b1;
      end
   end

   // Frame completion: publish command and raise single-cycle status pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd     <= '0;
         rdy     <= 1'b0;
         frm_err <= 1'b0;
      end else begin
         rdy     <= end_good;
         frm_err <= end_bad;
         if (end_good) begin
            cmd <= shift_reg;
         end
      end
   end

   assign busy = (state == SHIFT);

`ifdef MISO_TRISTATE_EN
   assign MISO = SS_n ? 1'bz : shift_reg[WIDTH-1];
`else
   assign MISO = shift_reg[WIDTH-1];
`endif

endmodule

// File: tb/tb_spi_serf.sv
// tb/tb_spi_serf.sv - randomized monarch stimulus against a bit-sequence model of spi_serf
module tb_spi_serf;
   localparam int WIDTH = 16;

`ifdef MISO_TRISTATE_EN
   localparam logic MISO_IDLE = 1'bz;
`else
   localparam logic MISO_IDLE = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst_n;
   logic             SS_n;
   logic             SCLK;
   logic             MOSI;
   logic [WIDTH-1:0] tx_data;
   wire              MISO;
   logic [WIDTH-1:0] cmd;
   logic             rdy;
   logic             frm_err;
   logic             busy;

   int tests = 0;
   int fails = 0;

   int   rdy_pulses = 0;
   int   rdy_cycles = 0;
   int   err_pulses = 0;
   int   err_cycles = 0;
   logic rdy_q = 1'b0;
   logic err_q = 1'b0;

   logic [WIDTH-1:0] model_cmd;

   spi_serf #(.WIDTH(WIDTH)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .SS_n    (SS_n),
      .SCLK    (SCLK),
      .MOSI    (MOSI),
      .tx_data (tx_data),
      .MISO    (MISO),
      .cmd     (cmd),
      .rdy     (rdy),
      .frm_err (frm_err),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   // Pulse/width monitor sampled away from the active edge
   always @(negedge clk) begin
      if (rdy) rdy_cycles = rdy_cycles + 1;
      if (rdy && !rdy_q) rdy_pulses = rdy_pulses + 1;
      if (frm_err) err_cycles = err_cycles + 1;
      if (frm_err && !err_q) err_pulses = err_pulses + 1;
      rdy_q = rdy;
      err_q = frm_err;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " cmd"}, 32'(cmd), 32'd0);
      check({tag, " rdy"}, 32'(rdy), 32'd0);
      check({tag, " frm_err"}, 32'(frm_err), 32'd0);
      check({tag, " busy"}, 32'(busy), 32'd0);
   endtask

   // One monarch bit: present data, low phase, rise (monarch samples), high phase
   task automatic sclk_bit(input logic b);
      MOSI = b;
      SCLK = 1'b0;
      repeat (16) @(negedge clk);
      SCLK = 1'b1;
   endtask

   // Full monarch frame of n bits; the serf's MISO stream is expected to be the
   // captured response followed by the command bits it has already received.
   task automatic run_frame(input string tag, input logic [WIDTH-1:0] tx,
                            input logic [31:0] bits, input int n);
      logic q[$];
      logic b;
      logic exp_bit;
      int r0, rc0, e0, ec0;
      tx_data = tx;
      q = {};
      for (int i = WIDTH - 1; i >= 0; i--) q.push_back(tx[i]);
      r0 = rdy_pulses; rc0 = rdy_cycles; e0 = err_pulses; ec0 = err_cycles;
      @(negedge clk);
      SS_n = 1'b0;
      repeat (16) @(negedge clk);
      check({tag, " busy in frame"}, 32'(busy), 32'd1);
      tx_data = 16'($urandom);
      for (int k = 0; k < n; k++) begin
         b = bits[n-1-k];
         sclk_bit(b);
         exp_bit = q.pop_front();
         check($sformatf("%s miso bit %0d", tag, k), 32'(MISO), 32'(exp_bit));
         q.push_back(b);
         repeat (16) @(negedge clk);
      end
      SS_n = 1'b1;
      repeat (4) @(negedge clk);
      if (n == WIDTH) model_cmd = bits[WIDTH-1:0];
      check({tag, " cmd"}, 32'(cmd), 32'(model_cmd));
      check({tag, " rdy pulses"}, 32'(rdy_pulses - r0), (n == WIDTH) ? 32'd1 : 32'd0);
      check({tag, " rdy width"}, 32'(rdy_cycles - rc0), (n == WIDTH) ? 32'd1 : 32'd0);
      check({tag, " err pulses"}, 32'(err_pulses - e0), (n != WIDTH) ? 32'd1 : 32'd0);
      check({tag, " err width"}, 32'(err_cycles - ec0), (n != WIDTH) ? 32'd1 : 32'd0);
      check({tag, " busy after"}, 32'(busy), 32'd0);
`ifdef MISO_TRISTATE_EN
      check({tag, " miso released"}, 32'(MISO), 32'(MISO_IDLE));
`endif
   endtask

   initial begin
      logic [31:0] rbits;
      int          rn;
      int          r0;
      logic [7:0]  part;

      // 1: reset state and SCLK activity while deselected
      rst_n = 1'b0; SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0; tx_data = '0;
      model_cmd = '0;
      repeat (4) @(negedge clk);
      check_reset_outputs("reset");
      check("reset miso", 32'(MISO), 32'(MISO_IDLE));
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      r0 = rdy_pulses + err_pulses;
      for (int i = 0; i < 4; i++) begin
         sclk_bit(1'($urandom));
         repeat (16) @(negedge clk);
      end
      repeat (4) @(negedge clk);
      check_reset_outputs("idle sclk");
      check("idle sclk miso", 32'(MISO), 32'(MISO_IDLE));
      check("idle sclk pulses", 32'(rdy_pulses + err_pulses - r0), 32'd0);

      // 2: single full frame
      run_frame("frame1234", 16'hA5C3, 32'h1234, WIDTH);

      // 3: back-to-back frames with a new response between them
      run_frame("b2b_ffff", 16'hA5C3, 32'hFFFF, WIDTH);
      run_frame("b2b_0001", 16'h8000, 32'h0001, WIDTH);

      // 4: short frame
      run_frame("short10", 16'h5A5A, 32'h2AB, 10);

      // 5: long frame followed by a good one
      run_frame("long17", 16'h3C3C, 32'h1_2345, 17);
      run_frame("frame_beef", 16'h0F0F, 32'hBEEF, WIDTH);

      // Randomized frames around the boundary lengths
      for (int f = 0; f < 8; f++) begin
         rn = ($urandom_range(0, 2) == 0) ? int'($urandom_range(14, 18)) : WIDTH;
         rbits = $urandom & ((32'd1 << rn) - 32'd1);
         run_frame($sformatf("rand%0d_n%0d", f, rn), 16'($urandom), rbits, rn);
      end

      // 6: reset asserted after 8 bits, remainder of the frame must be ignored
      part = 8'($urandom);
      tx_data = 16'($urandom);
      @(negedge clk);
      SS_n = 1'b0;
      repeat (16) @(negedge clk);
      for (int k = 0; k < 8; k++) begin
         sclk_bit(part[7-k]);
         repeat (16) @(negedge clk);
      end
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midframe reset");
      check("midframe reset miso", 32'(MISO), 32'd0);
      model_cmd = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      r0 = rdy_pulses;
      for (int k = 0; k < 8; k++) begin
         sclk_bit(1'($urandom));
         repeat (16) @(negedge clk);
      end
      SS_n = 1'b1;
      repeat (6) @(negedge clk);
      check("after reset no rdy", 32'(rdy_pulses - r0), 32'd0);
      check("after reset cmd", 32'(cmd), 32'd0);
`ifdef MISO_TRISTATE_EN
      check("after reset miso z", 32'(MISO), 32'(MISO_IDLE));
`endif
      run_frame("recover", 16'hC001, 32'($urandom) & 32'hFFFF, WIDTH);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
